// File: rtl/tx_packet_arbiter.sv
// Round-robin scheduler that lets NUM_REQ byte sources share one packet-transmit FSM.
// Grants one requester per packet, streams its payload bytes and waits for the FSM to finish.
module tx_packet_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       data_ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     tx_end_packet,
    input  logic                     tx_load,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [15:0]              pkt_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, GAP} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic [15:0]        pkt_count_reg;

    logic [IDX_W-1:0]   win;
    logic               win_valid;
    logic [LEN_W-1:0]   len_arr  [NUM_REQ];
    logic [7:0]         data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
            assign data_arr[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    // Scan from ptr+1 upward with wrap; iterating from the far end lets the nearest set bit win.
    always_comb begin
        int idx;
        idx       = 0;
        win       = ptr_reg;
        win_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                win       = IDX_W'(idx);
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        tx_start      = 1'b0;
        tx_data       = 8'h00;
        tx_end_packet = 1'b0;
        data_ack      = '0;
        busy          = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (win_valid)
                    state_next = START;
            end
            START: begin
                tx_start   = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                tx_data       = data_arr[ptr_reg];
                tx_end_packet = (remaining_reg == LEN_W'(1));
                if (tx_load) begin
                    data_ack = gnt_reg;
                    if (remaining_reg == LEN_W'(1))
                        state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done)
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_reg <= GAP_W'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            gnt_reg       <= '0;
            remaining_reg <= '0;
            gap_reg       <= '0;
            pkt_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        gnt_reg       <= NUM_REQ'(1) << win;
                        // A zero-length request still sends one byte.
                        remaining_reg <= (len_arr[win] == '0) ? LEN_W'(1) : len_arr[win];
                        ptr_reg       <= win;
                    end
                end
                STREAM: begin
                    if (tx_load)
                        remaining_reg <= remaining_reg - LEN_W'(1);
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        pkt_count_reg <= pkt_count_reg + 16'd1;
                        gnt_reg       <= '0;
                        gap_reg       <= GAP_W'(GAP_CYCLES);
                    end
                end
                GAP: begin
                    gap_reg <= gap_reg - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign pkt_count = pkt_count_reg;

endmodule
